// File: rtl/galaksija_pkg.sv
`default_nettype none
// ============================================================================
// Module      : galaksija_pkg
// Description : Shared types and default timing for the Galaksija tape player.
// Revision    : 1.0 - initial release
// ============================================================================
package galaksija_pkg;

    // Tape buffer is 16 KB.
    localparam int TAPE_ADDR_W       = 14;

    // Default pulse timing in CPU clocks.
    localparam int TAPE_SLOT_CYCLES  = 2351;
    localparam int TAPE_PULSE_CYCLES = 655;
    localparam int TAPE_BYTE_GAP     = 13000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } tape_state_e;

    // A '1' bit pulses in sub-slots 0 and 2, a '0' bit in sub-slots 0 and 1.
    function automatic logic slot_active(input logic bit_val, input logic [1:0] slot);
        return bit_val ? ~slot[0] : ~slot[1];
    endfunction

endpackage : galaksija_pkg
`default_nettype wire

// File: rtl/galaksija_tape_bitcell.sv
`default_nettype none
// ============================================================================
// Module      : galaksija_tape_bitcell
// Description : Generates the four-sub-slot pulse pattern for one tape bit.
//               start loads a bit and restarts the cell; cell_done is high
//               during the last cycle of sub-slot 3.
// Revision    : 1.0 - initial release
// ============================================================================
module galaksija_tape_bitcell
    import galaksija_pkg::*;
#(
    parameter int SLOT_CYCLES  = TAPE_SLOT_CYCLES,
    parameter int PULSE_CYCLES = TAPE_PULSE_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic start,
    input  logic bit_in,
    output logic cell_done,
    output logic level
);

    localparam int CNT_W = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_slot_last = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_pulse     = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_slot;
    logic             r_bit;
    logic             r_level;

    logic             w_busy_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_slot_nxt;
    logic             w_bit_nxt;
    logic             w_level_nxt;

    assign cell_done = r_busy && (r_slot == 2'd3) && (r_cnt == c_slot_last);
    assign level     = r_level;

    // Next counter/sub-slot state; level is derived from the next state so the
    // registered output lines up exactly with counter boundaries.
    always_comb begin
        w_busy_nxt = r_busy;
        w_cnt_nxt  = r_cnt;
        w_slot_nxt = r_slot;
        w_bit_nxt  = r_bit;
        if (clear) begin
            w_busy_nxt = 1'b0;
            w_cnt_nxt  = '0;
            w_slot_nxt = 2'd0;
            w_bit_nxt  = 1'b0;
        end else if (start) begin
            w_busy_nxt = 1'b1;
            w_cnt_nxt  = '0;
            w_slot_nxt = 2'd0;
            w_bit_nxt  = bit_in;
        end else if (cell_done) begin
            w_busy_nxt = 1'b0;
            w_cnt_nxt  = '0;
            w_slot_nxt = 2'd0;
        end else if (r_busy) begin
            if (r_cnt == c_slot_last) begin
                w_cnt_nxt  = '0;
                w_slot_nxt = r_slot + 2'd1;
            end else begin
                w_cnt_nxt  = r_cnt + c_cnt_one;
            end
        end
        w_level_nxt = ~(w_busy_nxt && slot_active(w_bit_nxt, w_slot_nxt) && (w_cnt_nxt < c_pulse));
    end

    // Cell state and registered pulse level; idle level is high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_slot  <= 2'd0;
            r_bit   <= 1'b0;
            r_level <= 1'b1;
        end else begin
            r_busy  <= w_busy_nxt;
            r_cnt   <= w_cnt_nxt;
            r_slot  <= w_slot_nxt;
            r_bit   <= w_bit_nxt;
            r_level <= w_level_nxt;
        end
    end

endmodule : galaksija_tape_bitcell
`default_nettype wire

// File: rtl/galaksija_tape_player.sv
`default_nettype none
// ============================================================================
// Module      : galaksija_tape_player
// Description : Cassette playback engine. Fetches bytes from the tape buffer
//               and serialises them LSB first into the Galaksija pulse
//               waveform on tape_bit.
// Revision    : 1.0 - initial release
// ============================================================================
module galaksija_tape_player
    import galaksija_pkg::*;
#(
    parameter int ADDR_W       = TAPE_ADDR_W,
    parameter int SLOT_CYCLES  = TAPE_SLOT_CYCLES,
    parameter int PULSE_CYCLES = TAPE_PULSE_CYCLES,
    parameter int BYTE_GAP     = TAPE_BYTE_GAP
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              download,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [7:0]        buf_data,
    output logic              tape_bit,
    output logic              playing,
    output logic              done
);

    localparam int GAP_W = (BYTE_GAP > 2) ? $clog2(BYTE_GAP) : 1;
    localparam logic [GAP_W-1:0]  c_gap_last = GAP_W'(BYTE_GAP - 1);
    localparam logic [GAP_W-1:0]  c_gap_one  = GAP_W'(1);
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_len_one  = (ADDR_W + 1)'(1);

    tape_state_e       r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_buf_addr, w_addr_nxt;
    logic [ADDR_W:0]   r_length;
    logic              r_dl_prev;
    logic [7:0]        r_byte, w_byte_nxt;
    logic [2:0]        r_bit_idx, w_idx_nxt;
    logic              r_fetch_ph, w_ph_nxt;
    logic [GAP_W-1:0]  r_gap_cnt, w_gap_nxt;
    logic              r_playing;
    logic              r_done;

    logic              w_abort;
    logic              w_start;
    logic              w_bit_in;
    logic              w_cell_done;
    logic              w_level;
    logic              w_dl_rise;
    logic [ADDR_W:0]   w_dl_len;
    logic [ADDR_W:0]   w_len_base;

    assign w_abort    = download | ~enable;
    assign w_dl_rise  = download & ~r_dl_prev;
    assign w_dl_len   = {1'b0, dl_addr} + c_len_one;
    assign w_len_base = w_dl_rise ? '0 : r_length;

    assign buf_addr = r_buf_addr;
    assign tape_bit = w_level;
    assign playing  = r_playing;
    assign done     = r_done;

    // Track the highest written address; a new download restarts the count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_length  <= '0;
            r_dl_prev <= 1'b0;
        end else begin
            r_dl_prev <= download;
            if (download && dl_wr && (w_dl_len > w_len_base)) begin
                r_length <= w_dl_len;
            end else if (w_dl_rise) begin
                r_length <= '0;
            end
        end
    end

    // Playback sequencing; abort (rewind) overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_buf_addr;
        w_byte_nxt  = r_byte;
        w_idx_nxt   = r_bit_idx;
        w_ph_nxt    = r_fetch_ph;
        w_gap_nxt   = r_gap_cnt;
        w_start     = 1'b0;
        w_bit_in    = 1'b0;
        if (w_abort) begin
            w_state_nxt = IDLE;
            w_addr_nxt  = '0;
            w_idx_nxt   = 3'd0;
            w_ph_nxt    = 1'b0;
            w_gap_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_length != '0) begin
                        w_state_nxt = FETCH;
                        w_addr_nxt  = '0;
                        w_ph_nxt    = 1'b0;
                    end
                end
                FETCH: begin
                    // Phase 0 presents the address, phase 1 sees the data.
                    if (!r_fetch_ph) begin
                        w_ph_nxt    = 1'b1;
                    end else begin
                        w_ph_nxt    = 1'b0;
                        w_byte_nxt  = buf_data;
                        w_idx_nxt   = 3'd0;
                        w_start     = 1'b1;
                        w_bit_in    = buf_data[0];
                        w_state_nxt = SEND;
                    end
                end
                SEND: begin
                    if (w_cell_done) begin
                        if (r_bit_idx == 3'd7) begin
                            w_state_nxt = GAP;
                            w_gap_nxt   = '0;
                        end else begin
                            w_idx_nxt   = r_bit_idx + 3'd1;
                            w_start     = 1'b1;
                            w_bit_in    = r_byte[r_bit_idx + 3'd1];
                        end
                    end
                end
                GAP: begin
                    if (r_gap_cnt == c_gap_last) begin
                        // Stay on the last byte's address so buf_addr never
                        // passes length-1.
                        if (({1'b0, r_buf_addr} + c_len_one) == r_length) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_state_nxt = FETCH;
                            w_addr_nxt  = r_buf_addr + c_addr_one;
                        end
                    end else begin
                        w_gap_nxt = r_gap_cnt + c_gap_one;
                    end
                end
                DONE: begin
                    w_state_nxt = DONE;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_addr_nxt  = '0;
                end
            endcase
        end
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_buf_addr <= '0;
            r_byte     <= 8'h00;
            r_bit_idx  <= 3'd0;
            r_fetch_ph <= 1'b0;
            r_gap_cnt  <= '0;
            r_playing  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_buf_addr <= w_addr_nxt;
            r_byte     <= w_byte_nxt;
            r_bit_idx  <= w_idx_nxt;
            r_fetch_ph <= w_ph_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_playing  <= (w_state_nxt == FETCH) || (w_state_nxt == SEND) || (w_state_nxt == GAP);
            r_done     <= (w_state_nxt == DONE);
        end
    end

    galaksija_tape_bitcell #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_bitcell (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (w_abort),
        .start     (w_start),
        .bit_in    (w_bit_in),
        .cell_done (w_cell_done),
        .level     (w_level)
    );

endmodule : galaksija_tape_player
`default_nettype wire

// File: tb/tb_galaksija_tape_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_galaksija_tape_player
// Description : Directed self-checking bench for galaksija_tape_player with
//               shortened timing (10-cycle sub-slots, 3-cycle pulses,
//               20-cycle byte gap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_galaksija_tape_player;

    localparam int ADDR_W = 8;
    localparam int SLOT   = 10;
    localparam int PULSE  = 3;
    localparam int GAPC   = 20;
    localparam int SEND_CYCLES = 32 * SLOT;

    logic              clk = 1'b0;
    logic              resetn;
    logic              enable;
    logic              download;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;
    logic              tape_bit;
    logic              playing;
    logic              done;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] exp_bytes [0:15];

    int vectors    = 0;
    int miscompares = 0;

    galaksija_tape_player #(
        .ADDR_W       (ADDR_W),
        .SLOT_CYCLES  (SLOT),
        .PULSE_CYCLES (PULSE),
        .BYTE_GAP     (GAPC)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (enable),
        .download (download),
        .dl_wr    (dl_wr),
        .dl_addr  (dl_addr),
        .buf_addr (buf_addr),
        .buf_data (buf_data),
        .tape_bit (tape_bit),
        .playing  (playing),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read tape buffer model.
    always @(posedge clk) buf_data <= mem[buf_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected level at cycle t of the SEND phase for byte b.
    function automatic logic exp_level(input logic [7:0] b, input int t);
        int  bi;
        int  s;
        int  c;
        logic act;
        bi = t / (4 * SLOT);
        s  = (t / SLOT) % 4;
        c  = t % SLOT;
        act = b[bi] ? ((s % 2) == 0) : (s < 2);
        return !(act && (c < PULSE));
    endfunction

    // Play n bytes from exp_bytes; caller has just made the start condition
    // true. Returns early after SEND cycle stop_t of byte stop_byte.
    task automatic play_bytes(input int n, input int stop_byte, input int stop_t);
        logic e;
        for (int i = 0; i < n; i++) begin
            step();
            vectors++;
            if (playing !== 1'b1 || tape_bit !== 1'b1 || done !== 1'b0 || buf_addr !== ADDR_W'(i)) begin
                $display("FAIL fetch byte%0d: playing=%b tape_bit=%b done=%b buf_addr=%0d, want 1 1 0 %0d",
                         i, playing, tape_bit, done, buf_addr, i);
                miscompares++;
            end
            step();
            vectors++;
            if (tape_bit !== 1'b1) begin
                $display("FAIL fetch2 byte%0d: tape_bit=%b want 1", i, tape_bit);
                miscompares++;
            end
            for (int t = 0; t < SEND_CYCLES; t++) begin
                step();
                e = exp_level(exp_bytes[i], t);
                vectors++;
                if (tape_bit !== e || playing !== 1'b1) begin
                    $display("FAIL send byte%0d t=%0d: tape_bit=%b playing=%b want %b 1",
                             i, t, tape_bit, playing, e);
                    miscompares++;
                end
                if (i == stop_byte && t == stop_t) return;
            end
            for (int g = 0; g < GAPC; g++) begin
                step();
                vectors++;
                if (tape_bit !== 1'b1 || playing !== 1'b1 || buf_addr !== ADDR_W'(i)) begin
                    $display("FAIL gap byte%0d g=%0d: tape_bit=%b playing=%b buf_addr=%0d want 1 1 %0d",
                             i, g, tape_bit, playing, buf_addr, i);
                    miscompares++;
                end
            end
        end
        step();
        vectors++;
        if (done !== 1'b1 || playing !== 1'b0 || tape_bit !== 1'b1 || buf_addr !== ADDR_W'(n - 1)) begin
            $display("FAIL done n=%0d: done=%b playing=%b tape_bit=%b buf_addr=%0d want 1 0 1 %0d",
                     n, done, playing, tape_bit, buf_addr, n - 1);
            miscompares++;
        end
    endtask

    // Load n bytes from exp_bytes; first write lands on the download rising edge.
    task automatic download_bytes(input int n);
        download = 1'b1;
        for (int i = 0; i < n; i++) begin
            dl_wr   = 1'b1;
            dl_addr = ADDR_W'(i);
            mem[i]  = exp_bytes[i];
            step();
            if (i == 0) begin
                vectors++;
                if (playing !== 1'b0 || done !== 1'b0 || tape_bit !== 1'b1 || buf_addr !== '0) begin
                    $display("FAIL dl_abort: playing=%b done=%b tape_bit=%b buf_addr=%0d want 0 0 1 0",
                             playing, done, tape_bit, buf_addr);
                    miscompares++;
                end
            end
        end
        dl_wr = 1'b0;
        step();
        download = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b0; download = 1'b0; dl_wr = 1'b0; dl_addr = '0;
        repeat (3) step();
        vectors++;
        if (tape_bit !== 1'b1 || playing !== 1'b0 || done !== 1'b0 || buf_addr !== '0) begin
            $display("FAIL reset: tape_bit=%b playing=%b done=%b buf_addr=%0d want 1 0 0 0",
                     tape_bit, playing, done, buf_addr);
            miscompares++;
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_zero_length();
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            vectors++;
            if (playing !== 1'b0 || tape_bit !== 1'b1 || done !== 1'b0) begin
                $display("FAIL zero_len c=%0d: playing=%b tape_bit=%b done=%b want 0 1 0",
                         i, playing, tape_bit, done);
                miscompares++;
            end
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_single_byte();
        exp_bytes[0] = 8'h01;
        download_bytes(1);
        enable = 1'b1;
        play_bytes(1, -1, 0);
        enable = 1'b0;
        step();
    endtask

    task automatic test_three_bytes();
        exp_bytes[0] = 8'hFF; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'hA5;
        download_bytes(3);
        enable = 1'b1;
        play_bytes(3, -1, 0);
        for (int i = 0; i < 30; i++) begin
            step();
            vectors++;
            if (done !== 1'b1 || tape_bit !== 1'b1 || buf_addr !== ADDR_W'(2)) begin
                $display("FAIL done_hold c=%0d: done=%b tape_bit=%b buf_addr=%0d want 1 1 2",
                         i, done, tape_bit, buf_addr);
                miscompares++;
            end
        end
    endtask

    task automatic test_abort_restart();
        enable = 1'b0;
        step();
        enable = 1'b1;
        // Stop inside the first low pulse of bit 1 of byte 1 (0x00).
        play_bytes(3, 1, 41);
        enable = 1'b0;
        step();
        vectors++;
        if (tape_bit !== 1'b1 || buf_addr !== '0 || playing !== 1'b0 || done !== 1'b0) begin
            $display("FAIL abort: tape_bit=%b buf_addr=%0d playing=%b done=%b want 1 0 0 0",
                     tape_bit, buf_addr, playing, done);
            miscompares++;
        end
        enable = 1'b1;
        play_bytes(3, -1, 0);
    endtask

    task automatic test_redownload_in_done();
        // Still in DONE with enable=1: playback resumes as soon as download drops.
        exp_bytes[0] = 8'h3C; exp_bytes[1] = 8'h81; exp_bytes[2] = 8'h00;
        exp_bytes[3] = 8'hFF; exp_bytes[4] = 8'h5A;
        download_bytes(5);
        play_bytes(5, -1, 0);
    endtask

    task automatic test_shrink();
        // A shorter download must forget the previous length of 5.
        exp_bytes[0] = 8'h80;
        download_bytes(1);
        play_bytes(1, -1, 0);
    endtask

    task automatic test_async_reset();
        enable = 1'b0;
        step();
        exp_bytes[0] = 8'h80;
        enable = 1'b1;
        // Stop at t=1: inside the first low pulse of bit 0.
        play_bytes(1, 0, 1);
        #2;
        resetn = 1'b0;
        #1;
        vectors++;
        if (tape_bit !== 1'b1 || playing !== 1'b0 || done !== 1'b0 || buf_addr !== '0) begin
            $display("FAIL async_reset: tape_bit=%b playing=%b done=%b buf_addr=%0d want 1 0 0 0",
                     tape_bit, playing, done, buf_addr);
            miscompares++;
        end
        step();
        resetn = 1'b1;
        // Length was cleared by reset, so enable alone must not start playback.
        for (int i = 0; i < 30; i++) begin
            step();
            vectors++;
            if (playing !== 1'b0 || tape_bit !== 1'b1) begin
                $display("FAIL reset_len c=%0d: playing=%b tape_bit=%b want 0 1", i, playing, tape_bit);
                miscompares++;
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) exp_bytes[i] = 8'h00;
        test_reset();
        test_zero_length();
        test_single_byte();
        test_three_bytes();
        test_abort_restart();
        test_redownload_in_done();
        test_shrink();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_galaksija_tape_player
`default_nettype wire
